tick_counter: RTL and testbench
===============================

// Module: tick_counter
// PURPOSE
//   Parametrised successor of the 8-bit limit counter. Counts enabled ticks from 0 up to a runtime
//   limit n_ticks, in one-shot (saturate) or periodic (wrap) mode, under start/clear control.
//   Provides a registered count, a terminal-count pulse and a post-reset watch pulse.
//   Used as the shared timeout/interval generator in the datapath control blocks.
// PARAMETERS
//   WIDTH     8   count width; n_ticks and data_o are WIDTH bits, range 0..2^WIDTH-1
//   PRESCALE  4   enabled cycles per count step (used only with TICK_COUNTER_PRESCALE_EN), >=1
// PORTS
//   clk      in   1      clock, all state on rising edge
//   rstn     in   1      reset, asynchronous, active-low
//   start_i  in   1      (re)start: count := 0, enter RUN
//   clr_i    in   1      synchronous clear: count := 0, enter IDLE
//   en_i     in   1      tick enable, qualifies count steps in RUN
//   mode_i   in   1      0 = one-shot saturate, 1 = periodic wrap; sampled every cycle
//   n_ticks  in   WIDTH  terminal count value, sampled every cycle
//   data_o   out  WIDTH  registered count, lags internal count by 1 cycle
//   tc_o     out  1      1-cycle terminal-count pulse, aligned with data_o == terminal value
//   busy_o   out  1      state == RUN
//   done_o   out  1      state == DONE (one-shot finished)
//   watch_o  out  1      1-cycle pulse on first clk edge after rstn deasserts
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE, cnt=0, prescaler=0, data_o=0, tc_o=0, watch_o=0.
//   FSM IDLE/RUN/DONE. Priority per edge: clr_i > start_i > count step.
//     clr_i=1: IDLE, cnt=0, prescaler=0 (from any state).
//     start_i=1: RUN, cnt=0, prescaler=0 (from any state, retrigger allowed mid-run).
//     IDLE/DONE without start_i: hold cnt.
//   adv = (state==RUN) & en_i (& prescaler strobe when the macro is set).
//   RUN on adv:
//     cnt < n_ticks  -> cnt := cnt+1
//     cnt >= n_ticks -> term event. Mode 0: DONE, cnt held. Mode 1: cnt := 0, stay RUN.
//   tc_o <= term event. data_o <= cnt.
//     Result: tc_o=1 in the same cycle that data_o shows the terminal value.
//   n_ticks=0: cnt stays 0. tc_o fires on every adv in mode 1, on the first adv in mode 0.
//   n_ticks lowered below cnt mid-run: the next adv is a term event (>= compare). No overflow.
//   cnt never exceeds max(n_ticks, value at limit change); the +1 never wraps the WIDTH-bit
//     register, because cnt < n_ticks <= 2^WIDTH-1.
//   en_i=0 in RUN: cnt and prescaler hold, no tc_o.
//   busy_o/done_o: decoded from the state register, no extra latency.
//   watch_o: synchroniser flop rstn_z, cleared by reset.
//     watch_o <= rstn & ~rstn_z, so it is high exactly one cycle after reset release.
//   Reset mid-operation aborts immediately. Outputs return to reset values asynchronously.
// CONFIGURATION
//   TICK_COUNTER_PRESCALE_EN defined:
//     - mod-PRESCALE prescaler advances on RUN & en_i; adv only when prescaler == PRESCALE-1
//       (the prescaler then wraps to 0).
//     - PRESCALE=1 behaves as undefined.
//   Undefined: no prescaler logic, adv = RUN & en_i, PRESCALE ignored.
// TESTING
//   1. Reset release, idle inputs -> watch_o=1 for exactly 1 cycle; data_o=0, tc_o=0, busy_o=0.
//   2. WIDTH=8, mode 0, n_ticks=3, start then en_i=1 constant:
//        data_o 0,0,1,2,3 ; tc_o=1 with data_o=3 ; then done_o=1, data_o holds 3.
//   3. Mode 1, n_ticks=2, en_i=1 for 9 cycles:
//        data_o 0,1,2,0,1,2,... ; tc_o pulses every 3rd cycle ; busy_o stays 1.
//   4. Mode 1, n_ticks=255, WIDTH=8: count reaches 255, tc_o pulses, returns to 0 (no 256 alias).
//      Then n_ticks=0 -> tc_o on every adv.
//   5. Mid-run at cnt=5: clr_i and start_i both high -> IDLE, cnt=0 (clr wins).
//      Next cycle, rstn pulsed low mid-run -> all outputs 0 immediately.
//   6. With TICK_COUNTER_PRESCALE_EN, PRESCALE=4, n_ticks=2, mode 0, en_i=1:
//        data_o steps every 4 cycles ; tc_o after 12 enabled cycles.
//      en_i gaps stretch the interval accordingly.

Source files
------------

// File: rtl/tick_counter.sv
// tick_counter: enabled-tick counter, 0..n_ticks, one-shot (saturate) or periodic (wrap) modes.
// Latency: data_o/tc_o registered, one cycle behind the internal count; busy_o/done_o decoded from state.
// Backpressure: none; en_i gaps stall counting. Optional prescaler under TICK_COUNTER_PRESCALE_EN.
module tick_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] n_ticks,
  output logic [WIDTH-1:0] data_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             watch_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             rstn_z;
  logic             adv;
  logic             term;

`ifdef TICK_COUNTER_PRESCALE_EN
  // Prescaler width kept at least 1 bit so PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;
  logic          strobe;

  assign strobe = (psc == PS_LAST);
  assign adv    = (state == RUN) && en_i && strobe;

  // Mod-PRESCALE prescaler: runs on enabled RUN cycles, zeroed on clear/start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc <= '0;
    end else if (clr_i || start_i) begin
      psc <= '0;
    end else if ((state == RUN) && en_i) begin
      psc <= strobe ? '0 : psc + 1'b1;
    end
  end
`else
  assign adv = (state == RUN) && en_i;
`endif

  // Greater-or-equal compare so a limit lowered below cnt terminates on the next step.
  assign term = adv && (cnt >= n_ticks);

  // Control FSM with count and registered outputs; clr beats start beats count step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      data_o <= '0;
      tc_o   <= 1'b0;
    end else begin
      data_o <= cnt;
      tc_o   <= term;
      if (clr_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (start_i) begin
        state <= RUN;
        cnt   <= '0;
      end else if (adv) begin
        if (cnt < n_ticks) begin
          cnt <= cnt + 1'b1;
        end else if (mode_i) begin
          cnt <= '0;
        end else begin
          state <= DONE;
        end
      end
    end
  end

  // Post-reset watch pulse: high for exactly the first edge after rstn releases.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstn_z  <= 1'b0;
      watch_o <= 1'b0;
    end else begin
      rstn_z  <= rstn;
      watch_o <= rstn & ~rstn_z;
    end
  end

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed checks of tick_counter (WIDTH=8) against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Prescaler section is compiled only when TICK_COUNTER_PRESCALE_EN is defined.
module tb_tick_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i, clr_i, en_i, mode_i;
  logic [7:0] n_ticks;
  logic [7:0] data_o;
  logic       tc_o, busy_o, done_o, watch_o;

  int total = 0;
  int bad   = 0;

  tick_counter #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start_i),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .n_ticks (n_ticks),
    .data_o  (data_o),
    .tc_o    (tc_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .watch_o (watch_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; clr_i = 1'b0; en_i = 1'b0; mode_i = 1'b0; n_ticks = 8'd0;
    tick(); tick();
    chk("rst_data", data_o, 0);
    chk("rst_watch", watch_o, 0);

    // Reset release with idle inputs.
    rstn = 1'b1;
    tick();
    chk("watch_hi", watch_o, 1);
    chk("post_rst_data", data_o, 0);
    chk("post_rst_tc", tc_o, 0);
    chk("post_rst_busy", busy_o, 0);
    tick();
    chk("watch_lo", watch_o, 0);

    // One-shot, n_ticks=3.
    mode_i = 1'b0; n_ticks = 8'd3; start_i = 1'b1; en_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("os_d0", data_o, 0);
    chk("os_busy", busy_o, 1);
    tick(); chk("os_d1", data_o, 0); chk("os_tc1", tc_o, 0);
    tick(); chk("os_d2", data_o, 1);
    tick(); chk("os_d3", data_o, 2); chk("os_tc3", tc_o, 0);
    tick(); chk("os_d4", data_o, 3); chk("os_tc4", tc_o, 1); chk("os_done", done_o, 1);
    tick(); chk("os_hold", data_o, 3); chk("os_tc_end", tc_o, 0); chk("os_done2", done_o, 1);

    // Periodic, n_ticks=2.
    mode_i = 1'b1; n_ticks = 8'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("per_d%0d", i), data_o, i % 3);
      chk($sformatf("per_tc%0d", i), tc_o, (i % 3 == 2) ? 1 : 0);
      chk($sformatf("per_busy%0d", i), busy_o, 1);
    end

    // Periodic at full range, then limit dropped to 0.
    n_ticks = 8'd255; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 256; i++) tick();
    chk("full_pre", data_o, 254);
    tick();
    chk("full_max", data_o, 255);
    chk("full_tc", tc_o, 1);
    tick();
    chk("full_wrap", data_o, 0);
    chk("full_tc_off", tc_o, 0);
    n_ticks = 8'd0;
    tick(); chk("zero_tc0", tc_o, 1); chk("zero_d0", data_o, 1);
    tick(); chk("zero_tc1", tc_o, 1); chk("zero_d1", data_o, 0);
    tick(); chk("zero_tc2", tc_o, 1); chk("zero_busy", busy_o, 1);

    // One-shot with n_ticks=0: terminates on first step.
    mode_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); chk("os0_tc", tc_o, 1); chk("os0_done", done_o, 1); chk("os0_d", data_o, 0);

    // Enable gap holds, then clr and start together at cnt=5.
    n_ticks = 8'd10; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("gap_pre", data_o, 4);
    en_i = 1'b0;
    tick(); chk("gap_d0", data_o, 5);
    tick(); chk("gap_d1", data_o, 5); chk("gap_tc", tc_o, 0);
    clr_i = 1'b1; start_i = 1'b1;
    tick();
    clr_i = 1'b0; start_i = 1'b0;
    chk("clr_busy", busy_o, 0);
    chk("clr_done", done_o, 0);
    tick(); chk("clr_cnt", data_o, 0);

    // Asynchronous reset mid-run.
    en_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    chk("run_pre", data_o, 2);
    rstn = 1'b0;
    #1;
    chk("ar_data", data_o, 0);
    chk("ar_tc", tc_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_done", done_o, 0);
    chk("ar_watch", watch_o, 0);
    tick();
    rstn = 1'b1; en_i = 1'b0;
    tick();
    chk("ar_watch_hi", watch_o, 1);

`ifdef TICK_COUNTER_PRESCALE_EN
    // Prescaled one-shot, n_ticks=2: steps every 4 enabled cycles, tc at enabled cycle 12.
    mode_i = 1'b0; n_ticks = 8'd2; en_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4)  chk("ps_d4", data_o, 0);
      if (i == 5)  chk("ps_d5", data_o, 1);
      if (i == 9)  chk("ps_d9", data_o, 2);
      if (i == 11) chk("ps_tc11", tc_o, 0);
      if (i == 12) begin
        chk("ps_tc12", tc_o, 1);
        chk("ps_done", done_o, 1);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
